// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared types and constants for the MIPS core control path.
//   hazard_state_t : hazard sequencer FSM states (run / drop stale fetch)
//   REG_ZERO       : architectural zero register index; writes to it never
//                    create a dependency
package mips_core_pkg;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DROP = 1'b1
    } hazard_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_control_ifc.sv
// hazard_control_ifc: stall/flush control pair for one pipeline register.
//   stall : hold the register contents (dominates flush)
//   flush : load a bubble into the register
interface hazard_control_ifc;
    logic stall;
    logic flush;

    modport ctl (output stall, output flush);
    modport pipe (input stall, input flush);
endinterface

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: combinational load-use comparator.
//   i_id_valid, i_id_uses_rs/rt, i_id_rs/rt : ID-stage source operands
//   i_ex_is_load, i_ex_rw_addr              : EX-stage load destination
//   o_lu                                    : ID needs the EX load result
module hazard_lu_detect
    import mips_core_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_id_valid,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rw_addr,
    output logic                  o_lu
);

    logic w_ld_live;
    logic w_rs_hit;
    logic w_rt_hit;

    // A load to r0 produces nothing that a consumer could wait for.
    assign w_ld_live = i_id_valid & i_ex_is_load &
                       (i_ex_rw_addr != REG_ADDR_W'(REG_ZERO));
    assign w_rs_hit  = i_id_uses_rs & (i_id_rs == i_ex_rw_addr);
    assign w_rt_hit  = i_id_uses_rt & (i_id_rt == i_ex_rw_addr);
    assign o_lu      = w_ld_live & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: central hazard controller for the 5-stage in-order core.
// Combines I-cache miss, D-cache miss, load-use and branch mispredict into
// stall/flush pairs for IF/ID, ID/EX, EX/MEM, MEM/WB plus a PC stall and the
// redirect strobe. A two-state FSM remembers a wrong-path fetch that was
// still outstanding in the I-cache at redirect time and discards it.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   i_ic_miss, i_dc_miss              cache miss indications
//   i_id_*                            ID-stage operand info
//   i_ex_is_load, i_ex_rw_addr        EX-stage load destination
//   i_ex_mispredict                   EX branch resolved wrong
//   o_pc_stall, o_redirect            PC control
//   o_{i2d,d2e,e2m,m2w}_{stall,flush} pipeline register control
//
// Optional: define HAZARD_PERF_CNT_EN to add saturating counters
//   o_stall_cycles, o_lu_bubbles, o_redirects (CNT_W bits each).
module hazard_sequencer
    import mips_core_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ic_miss,
    input  logic                  i_dc_miss,
    input  logic                  i_id_valid,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rw_addr,
    input  logic                  i_ex_mispredict,
    output logic                  o_pc_stall,
    output logic                  o_redirect,
    output logic                  o_i2d_stall,
    output logic                  o_i2d_flush,
    output logic                  o_d2e_stall,
    output logic                  o_d2e_flush,
    output logic                  o_e2m_stall,
    output logic                  o_e2m_flush,
    output logic                  o_m2w_stall,
    output logic                  o_m2w_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      o_stall_cycles,
    output logic [CNT_W-1:0]      o_lu_bubbles,
    output logic [CNT_W-1:0]      o_redirects
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("hazard_sequencer: CNT_W must be at least 1");
    end

    hazard_state_t r_state;
    hazard_state_t w_next;

    logic w_lu;
    logic w_pc_stall;
    logic w_redirect;
    logic w_lu_bubble;

    hazard_control_ifc w_i2d ();
    hazard_control_ifc w_d2e ();
    hazard_control_ifc w_e2m ();
    hazard_control_ifc w_m2w ();

    hazard_lu_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_detect (
        .i_id_valid   (i_id_valid),
        .i_id_uses_rs (i_id_uses_rs),
        .i_id_uses_rt (i_id_uses_rt),
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_ex_is_load (i_ex_is_load),
        .i_ex_rw_addr (i_ex_rw_addr),
        .o_lu         (w_lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_stall  = 1'b0;
        w_redirect  = 1'b0;
        w_lu_bubble = 1'b0;
        w_i2d.stall = 1'b0;
        w_i2d.flush = 1'b0;
        w_d2e.stall = 1'b0;
        w_d2e.flush = 1'b0;
        w_e2m.stall = 1'b0;
        w_e2m.flush = 1'b0;
        w_m2w.stall = 1'b0;
        w_m2w.flush = 1'b0;

        if (!rst_n) begin
            // Outputs are forced quiet while reset is held.
            w_next = S_RUN;
        end else if (i_dc_miss) begin
            // Everything up to MEM freezes; the held EX mispredict is
            // re-evaluated once the miss clears, so no redirect here.
            w_pc_stall  = 1'b1;
            w_i2d.stall = 1'b1;
            w_d2e.stall = 1'b1;
            w_e2m.stall = 1'b1;
            w_m2w.flush = 1'b1;
        end else if (i_ex_mispredict) begin
            w_redirect  = 1'b1;
            w_i2d.flush = 1'b1;
            w_d2e.flush = 1'b1;
            // An outstanding fetch belongs to the wrong path; remember to
            // throw away the line when it finally arrives.
            if (i_ic_miss) begin
                w_next = S_DROP;
            end
        end else if (r_state == S_DROP && !i_ic_miss) begin
            // Stale wrong-path line is on the fetch bus this cycle: keep
            // the PC (already on the right path) and do not latch the line.
            w_pc_stall = 1'b1;
            w_next     = S_RUN;
            if (w_lu) begin
                w_i2d.stall = 1'b1;
                w_d2e.flush = 1'b1;
                w_lu_bubble = 1'b1;
            end else begin
                w_i2d.flush = 1'b1;
            end
        end else if (w_lu) begin
            // Holding IF/ID wins over an I-cache miss bubble so the
            // consumer is not lost.
            w_pc_stall  = 1'b1;
            w_i2d.stall = 1'b1;
            w_d2e.flush = 1'b1;
            w_lu_bubble = 1'b1;
        end else if (i_ic_miss) begin
            w_pc_stall  = 1'b1;
            w_i2d.flush = 1'b1;
        end
    end

    assign o_pc_stall  = w_pc_stall;
    assign o_redirect  = w_redirect;
    assign o_i2d_stall = w_i2d.stall;
    assign o_i2d_flush = w_i2d.flush;
    assign o_d2e_stall = w_d2e.stall;
    assign o_d2e_flush = w_d2e.flush;
    assign o_e2m_stall = w_e2m.stall;
    assign o_e2m_flush = w_e2m.flush;
    assign o_m2w_stall = w_m2w.stall;
    assign o_m2w_flush = w_m2w.flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_lu_bubbles;
    logic [CNT_W-1:0] r_redirects;

    // Saturating counters; pipeline flushes never touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_lu_bubbles   <= '0;
            r_redirects    <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_lu_bubble && (r_lu_bubbles != '1)) begin
                r_lu_bubbles <= r_lu_bubbles + CNT_W'(1);
            end
            if (w_redirect && (r_redirects != '1)) begin
                r_redirects <= r_redirects + CNT_W'(1);
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_lu_bubbles   = r_lu_bubbles;
    assign o_redirects    = r_redirects;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed, table-driven bench for hazard_sequencer.
// Control outputs are compared as one 10-bit word:
//   {pc_stall, redirect, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f}
module tb_hazard_sequencer;

    localparam int AW = 5;
    localparam int CW = 32;

    localparam logic [9:0] E_IDLE = 10'b00_0000_0000;
    localparam logic [9:0] E_LU   = 10'b10_1001_0000;
    localparam logic [9:0] E_DC   = 10'b10_1010_1001;
    localparam logic [9:0] E_MP   = 10'b01_0101_0000;
    localparam logic [9:0] E_IC   = 10'b10_0100_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic, dc, idv, urs, urt, ld, mp;
    logic [AW-1:0] rs, rt, rw;
    logic          pc_s, rd, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] c_stall, c_lu, c_rd;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_ic_miss       (ic),
        .i_dc_miss       (dc),
        .i_id_valid      (idv),
        .i_id_uses_rs    (urs),
        .i_id_uses_rt    (urt),
        .i_id_rs         (rs),
        .i_id_rt         (rt),
        .i_ex_is_load    (ld),
        .i_ex_rw_addr    (rw),
        .i_ex_mispredict (mp),
        .o_pc_stall      (pc_s),
        .o_redirect      (rd),
        .o_i2d_stall     (i2d_s),
        .o_i2d_flush     (i2d_f),
        .o_d2e_stall     (d2e_s),
        .o_d2e_flush     (d2e_f),
        .o_e2m_stall     (e2m_s),
        .o_e2m_flush     (e2m_f),
        .o_m2w_stall     (m2w_s),
        .o_m2w_flush     (m2w_f)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cycles  (c_stall),
        .o_lu_bubbles    (c_lu),
        .o_redirects     (c_rd)
`endif
    );

    typedef struct {
        string         name;
        logic          ic, dc, idv, urs, urt, ld, mp;
        logic [AW-1:0] rs, rt, rw;
        logic [9:0]    exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] act();
        return {pc_s, rd, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f};
    endfunction

    task automatic add(input string nm, input logic a_ic, a_dc, a_idv, a_urs, a_urt,
                       input logic [AW-1:0] a_rs, a_rt, input logic a_ld,
                       input logic [AW-1:0] a_rw, input logic a_mp, input logic [9:0] a_exp);
        vec_t v;
        v.name = nm; v.ic = a_ic; v.dc = a_dc; v.idv = a_idv; v.urs = a_urs; v.urt = a_urt;
        v.rs = a_rs; v.rt = a_rt; v.ld = a_ld; v.rw = a_rw; v.mp = a_mp; v.exp = a_exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        ic = v.ic; dc = v.dc; idv = v.idv; urs = v.urs; urt = v.urt;
        rs = v.rs; rt = v.rt; ld = v.ld; rw = v.rw; mp = v.mp;
    endtask

    task automatic drive_idle();
        ic = 0; dc = 0; idv = 0; urs = 0; urt = 0; rs = 0; rt = 0; ld = 0; rw = 0; mp = 0;
    endtask

    task automatic chk(input string nm, input logic [9:0] exp);
        logic [9:0] a;
        a = act();
        n_checks++;
        if (a !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, exp, $time);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic chk_cnt(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask
`endif

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   name           ic dc idv urs urt rs rt ld rw mp exp
        add("idle",          0, 0, 1, 1, 1, 1, 2, 0, 0, 0, E_IDLE);
        add("lu_rs",         0, 0, 1, 1, 0, 5, 0, 1, 5, 0, E_LU);
        add("lu_after",      0, 0, 1, 1, 0, 5, 0, 0, 5, 0, E_IDLE);
        add("lu_r0",         0, 0, 1, 1, 0, 0, 0, 1, 0, 0, E_IDLE);
        add("lu_rt",         0, 0, 1, 0, 1, 3, 7, 1, 7, 0, E_LU);
        add("lu_rs_unused",  0, 0, 1, 0, 0, 9, 1, 1, 9, 0, E_IDLE);
        add("lu_id_invalid", 0, 0, 0, 1, 1, 4, 4, 1, 4, 0, E_IDLE);
        add("dc_mp_1",       0, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_DC);
        add("dc_mp_2",       0, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_DC);
        add("dc_mp_3",       0, 1, 0, 0, 0, 0, 0, 0, 0, 1, E_DC);
        add("mp_after_dc",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MP);
        add("ic_1",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IC);
        add("ic_2",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IC);
        add("ic_3",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IC);
        add("ic_4",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IC);
        add("lu_and_ic",     1, 0, 1, 1, 0, 6, 0, 1, 6, 0, E_LU);
        add("mp_ic_enter",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MP);
        add("drop_wait",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IC);
        add("drop_discard",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IC);
        add("run_clean",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
        add("mp_ic_enter2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MP);
        add("drop_dc",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_DC);
        add("drop_mp",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_MP);
        add("drop_discard2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IC);
        add("run_clean2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

        // Reset with hazards on the inputs: outputs must stay quiet.
        rst_n = 1'b0;
        drive(vecs[1]);
        ic = 1'b1;
        mp = 1'b1;
        #3;
        chk("reset_quiet", E_IDLE);
        next_cycle();
        rst_n = 1'b1;
        drive_idle();
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #3;
            chk(vecs[i].name, vecs[i].exp);
            next_cycle();
        end

        // Async reset while in S_DROP, then no leftover discard.
        ic = 1'b1; mp = 1'b1;
        #3;
        chk("rst_seq_enter", E_MP);
        next_cycle();
        mp = 1'b0;
        #2;
        chk("rst_seq_drop", E_IC);
        rst_n = 1'b0;
        #1;
        chk("rst_seq_async", E_IDLE);
        next_cycle();
        rst_n = 1'b1;
        drive_idle();
        #2;
        chk("rst_seq_no_drop", E_IDLE);
        next_cycle();

`ifdef HAZARD_PERF_CNT_EN
        // Counters were cleared by the reset above.
        idv = 1; urs = 1; rs = 5; ld = 1; rw = 5;
        next_cycle();
        drive_idle();
        next_cycle();
        idv = 1; urt = 1; rt = 8; ld = 1; rw = 8;
        next_cycle();
        drive_idle();
        next_cycle();
        mp = 1;
        next_cycle();
        drive_idle();
        #2;
        chk_cnt("cnt_lu_bubbles", c_lu, CW'(2));
        chk_cnt("cnt_redirects", c_rd, CW'(1));
        chk_cnt("cnt_stall_cycles", c_stall, CW'(2));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central hazard controller for the 5-stage in-order MIPS core.
- Generates per-register stall/flush pairs for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC stall.
- Sequences four hazard sources: I-cache miss, D-cache miss, load-use dependency, and branch mispredict.
- A small FSM tracks wrong-path fetches still outstanding in the I-cache when a redirect occurs, and discards them.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 32, width of optional performance counters

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_ic_miss  input  1  I-cache cannot deliver this cycle
i_dc_miss  input  1  D-cache busy with MEM-stage access this cycle
i_id_valid  input  1  ID stage holds a valid instruction
i_id_uses_rs  input  1  ID instruction reads rs
i_id_uses_rt  input  1  ID instruction reads rt
i_id_rs  input  REG_ADDR_W  ID rs address
i_id_rt  input  REG_ADDR_W  ID rt address
i_ex_is_load  input  1  EX instruction is a load
i_ex_rw_addr  input  REG_ADDR_W  EX destination register
i_ex_mispredict  input  1  EX branch resolved against its prediction
o_pc_stall  output  1  hold PC
o_redirect  output  1  load PC from the EX-resolved target this cycle
o_i2d_stall, o_i2d_flush  output  1 each  IF/ID register control
o_d2e_stall, o_d2e_flush  output  1 each  ID/EX register control
o_e2m_stall, o_e2m_flush  output  1 each  EX/MEM register control
o_m2w_stall, o_m2w_flush  output  1 each  MEM/WB register control

Behaviour:
- All control outputs are combinational from inputs and state, so they take effect in the same cycle.
- State: S_RUN, S_DROP. Reset: state = S_RUN.
- While rst_n is low, all outputs are 0. Reset mid-miss returns to S_RUN with no pending drop.
- Register semantics: stall dominates flush. A stalled register holds its value regardless of flush.
- Load-use hazard (lu) =
  - i_id_valid & i_ex_is_load & i_ex_rw_addr != 0, and
  - (i_id_uses_rs & i_id_rs == i_ex_rw_addr) | (i_id_uses_rt & i_id_rt == i_ex_rw_addr).
- Priority, highest first:
  1. i_dc_miss:
     - pc, i2d, d2e, e2m stall.
     - m2w flush (bubble into WB).
     - o_redirect = 0, even if a mispredict is present. The EX instruction is held, so the mispredict is re-evaluated when the miss clears.
  2. i_ex_mispredict:
     - o_redirect = 1.
     - i2d flush, d2e flush; pc not stalled.
     - If i_ic_miss is also set (wrong-path fetch outstanding), next state = S_DROP.
  3. lu:
     - pc, i2d stall.
     - d2e flush (one bubble). EX/MEM/WB advance.
     - Exactly one bubble per load-use pair.
  4. i_ic_miss:
     - pc stall.
     - i2d flush (bubble). Downstream advances.
- S_DROP:
  - The first cycle with !i_ic_miss is the stale wrong-path line returning. i2d flush and pc stall are both asserted for that one cycle, then the FSM goes to S_RUN.
  - While i_ic_miss stays high, remain in S_DROP.
  - dc_miss in S_DROP: rule 1 applies and the state holds.
  - A new mispredict in S_DROP: stay in S_DROP.
- Simultaneous lu and i_ic_miss: lu controls apply (i2d stall, not flush).
- No outputs are registered. The only latency is the one-cycle S_DROP discard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs o_stall_cycles, o_lu_bubbles and o_redirects, each CNT_W bits.
  - o_stall_cycles increments on any cycle with o_pc_stall.
  - o_lu_bubbles increments on rule-3 cycles.
  - o_redirects increments on o_redirect.
  - All counters reset to 0, saturate at all-ones, and are not cleared by flushes.
- When undefined, these ports and registers are absent. Core behaviour is identical either way.

Decomposition:
- mips_core_pkg additions:
  - typedef enum logic [0:0] {S_RUN, S_DROP} hazard_state_t.
  - REG_ZERO constant.
- Sub-module hazard_lu_detect: a purely combinational load-use comparator, instantiated once.
- Outputs map onto the four hazard_control_ifc instances at the top level.

Test Plan:
- Load r5 in EX; ID add reads rs=5 -> one cycle with pc/i2d stall and d2e flush, then normal flow. With rs=0 and EX rw=0 -> no stall.
- i_dc_miss high for 3 cycles with a mispredict in EX -> pc/i2d/d2e/e2m stall and m2w flush for 3 cycles, o_redirect=0. On cycle 4: o_redirect=1, i2d/d2e flush.
- Mispredict with i_ic_miss high, then ic_miss low 2 cycles later -> S_DROP. The first ready cycle gives i2d flush and pc stall; the next cycle is S_RUN with clean fetch.
- i_ic_miss alone for 4 cycles -> pc stall and i2d flush each cycle, downstream stalls 0.
- rst_n asserted while in S_DROP -> all outputs 0 immediately. After release: S_RUN, no spurious drop.
- With HAZARD_PERF_CNT_EN: run 2 load-use pairs and 1 mispredict -> o_lu_bubbles=2, o_redirects=1, o_stall_cycles=2.
